// File: rtl/debug_pkg.sv
// Shared command codes, FSM state encoding and byte-framing constants
// for the debug controller.
package debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    D_LOAD,
    D_SEND
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Presents a loaded 32-bit word as BYTES_PER_WORD bytes, MSB first, over
// a valid/ready handshake; o_done pulses with the final accepted byte.
module word_serializer
  import debug_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_fire;
  logic             w_last;

  assign w_fire  = r_valid && i_ready;
  assign w_last  = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_data  = r_shift[31:24];
  assign o_valid = r_valid;
  assign o_done  = w_fire && w_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      // Last byte stays on o_data after completion; only valid drops.
      if (w_last) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host-driven debug controller: run-to-halt, single-step and a state dump
// of the PC followed by N_WORDS debug-bus words, streamed out as bytes.
module debug_unit
  import debug_pkg::*;
#(
  parameter int N_WORDS  = 32,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        halted,
  input  logic [31:0] pc_value,
  input  logic [31:0] dbg_data,
  output logic        pipe_en,
  output logic        debugMode,
  output logic [31:0] DebugAddress
);

  localparam int IDX_W = $clog2(N_WORDS + 1);
  localparam int LAT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_item, w_item_nxt;
  logic [IDX_W-1:0] r_addr, w_addr_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic             w_load;
  logic             w_done;
  logic [31:0]      w_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_item  <= '0;
      r_addr  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_item  <= w_item_nxt;
      r_addr  <= w_addr_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_item_nxt  = r_item;
    w_addr_nxt  = r_addr;
    w_lat_nxt   = r_lat;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:  w_state_nxt = RUN;
            CMD_STEP: w_state_nxt = STEP;
            CMD_DUMP: begin
              w_state_nxt = D_LOAD;
              w_item_nxt  = '0;
              w_addr_nxt  = '0;
              w_lat_nxt   = '0;
            end
            default:  w_state_nxt = IDLE;
          endcase
        end
      end
      RUN: begin
        if (halted) w_state_nxt = IDLE;
      end
      STEP: w_state_nxt = IDLE;
      D_LOAD: begin
        if (r_lat == LAT_W'(READ_LAT)) begin
          w_load      = 1'b1;
          w_state_nxt = D_SEND;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      D_SEND: begin
        if (w_done) begin
          if (r_item == IDX_W'(N_WORDS)) begin
            w_state_nxt = IDLE;
          end else begin
            // Item k+1 reads debug word k, so the old item index is the new address.
            w_state_nxt = D_LOAD;
            w_item_nxt  = r_item + 1'b1;
            w_addr_nxt  = r_item;
            w_lat_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_word       = (r_item == '0) ? pc_value : dbg_data;
  assign pipe_en      = ((r_state == RUN) && !halted) || (r_state == STEP);
  assign debugMode    = !((r_state == RUN) || (r_state == STEP));
  assign DebugAddress = 32'(r_addr);

  word_serializer u_ser (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load),
    .i_word  (w_word),
    .i_ready (tx_ready),
    .o_data  (tx_data),
    .o_valid (tx_valid),
    .o_done  (w_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: random command mix against a byte-level
// dump model and cycle-count model of run/step.
module tb_debug_unit;

  localparam int NW = 2;
  localparam logic [7:0] C_RUN  = 8'h63;
  localparam logic [7:0] C_STEP = 8'h73;
  localparam logic [7:0] C_DUMP = 8'h64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halted;
  logic [31:0] pc_value;
  logic [31:0] dbg_data;
  logic        pipe_en;
  logic        debugMode;
  logic [31:0] DebugAddress;

  int         checks = 0;
  int         errors = 0;
  int         pe_cnt = 0;
  int         hs_cnt = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] exp_q[$];

  debug_unit #(.N_WORDS(NW), .READ_LAT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .halted       (halted),
    .pc_value     (pc_value),
    .dbg_data     (dbg_data),
    .pipe_en      (pipe_en),
    .debugMode    (debugMode),
    .DebugAddress (DebugAddress)
  );

  always #5 clk = ~clk;

  // Debug read port with one cycle of latency.
  always @(posedge clk) dbg_data <= 32'hA5A5_0000 + DebugAddress;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  initial begin
    bit         stall_prev;
    logic [7:0] data_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_data", 32'(tx_data), 32'(data_prev));
        end
        if (pipe_en) begin
          pe_cnt++;
          chk("debugmode_while_running", 32'(debugMode), 32'd0);
        end
        if (tx_valid && tx_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte got %h expected none", tx_data);
          end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
        end
        stall_prev = tx_valid && !tx_ready;
        data_prev  = tx_data;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endfunction

  function automatic void push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int i = 0; i < NW; i++) push_word(32'hA5A5_0000 + 32'(i));
  endfunction

  task automatic do_run(input int k);
    int pe0;
    pe0 = pe_cnt;
    send_cmd(C_RUN);
    repeat (k) @(posedge clk);
    #1;
    halted = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("run_cycles", 32'(pe_cnt - pe0), 32'(k));
    chk("run_back_idle", 32'(debugMode), 32'd1);
    halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("run_stays_idle", 32'(pe_cnt - pe0), 32'(k));
  endtask

  task automatic do_step();
    int pe0;
    pe0 = pe_cnt;
    send_cmd(C_STEP);
    rx_data  = C_STEP;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("step_cycles", 32'(pe_cnt - pe0), 32'd1);
    chk("step_back_idle", 32'(debugMode), 32'd1);
  endtask

  task automatic do_run_halted();
    int pe0;
    halted = 1'b1;
    pe0 = pe_cnt;
    send_cmd(C_RUN);
    repeat (4) @(posedge clk);
    #1;
    chk("run_halted_cycles", 32'(pe_cnt - pe0), 32'd0);
    chk("run_halted_idle", 32'(debugMode), 32'd1);
    halted = 1'b0;
  endtask

  task automatic do_unknown();
    logic [7:0] b;
    int pe0, hs0;
    do b = 8'($urandom_range(0, 255));
    while (b == C_RUN || b == C_STEP || b == C_DUMP);
    pe0 = pe_cnt;
    hs0 = hs_cnt;
    send_cmd(b);
    repeat (5) @(posedge clk);
    #1;
    chk("unknown_no_run", 32'(pe_cnt - pe0), 32'd0);
    chk("unknown_no_tx", 32'(hs_cnt - hs0), 32'd0);
    chk("unknown_dbgmode", 32'(debugMode), 32'd1);
    chk("unknown_tx_valid", 32'(tx_valid), 32'd0);
  endtask

  task automatic wait_dump();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 800) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("dump_all_bytes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("dump_end_tx_valid", 32'(tx_valid), 32'd0);
    chk("dump_end_dbgmode", 32'(debugMode), 32'd1);
    chk("dump_end_addr", DebugAddress, 32'(NW - 1));
  endtask

  task automatic do_dump(input bit rdy, input logic [31:0] pc);
    rand_rdy = rdy;
    pc_value = pc;
    push_dump(pc);
    send_cmd(C_DUMP);
    wait_dump();
    rand_rdy = 1'b0;
  endtask

  initial begin
    int hs0, n;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halted   = 1'b0;
    pc_value = 32'h0000_0040;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_pipe_en", 32'(pipe_en), 32'd0);
    chk("reset_dbgmode", 32'(debugMode), 32'd1);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_addr", DebugAddress, 32'd0);

    do_step();
    do_run(7);
    do_run_halted();
    do_unknown();
    do_dump(1'b0, 32'h0000_0040);
    do_dump(1'b1, 32'h0000_0040);

    // Abandon a dump after five bytes.
    pc_value = 32'h0000_0040;
    push_dump(pc_value);
    hs0 = hs_cnt;
    send_cmd(C_DUMP);
    n = 0;
    while (hs_cnt - hs0 < 5 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("partial_dump_progress", 32'(hs_cnt - hs0 >= 5), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("async_rst_addr", DebugAddress, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_dump(1'b1, 32'h0000_0040);

    // Abandon a free run.
    send_cmd(C_RUN);
    repeat (3) @(posedge clk);
    #1;
    chk("run_active", 32'(pipe_en), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_run_pipe_en", 32'(pipe_en), 32'd0);
    chk("async_rst_run_dbgmode", 32'(debugMode), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0: do_run(int'($urandom_range(1, 10)));
        1: do_step();
        2: do_dump(1'($urandom_range(0, 1)), $urandom);
        default: do_unknown();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
